vxe_txnreq_tracker: RTL and testbench

Request-side transaction tracker for a VxEngine memory port. Accepts encoded 44-bit request vectors (txnid[43:38], rnw[37], addr[36:0]) over a valid/ready handshake and buffers them in a small in-order FIFO. Decodes the FIFO head and issues it to the memory interface with a 40-bit byte address. Keeps a 64-entry in-flight table so that a transaction ID is never reissued before its response retires it.

---
 rtl/vxe_txnreq_tracker_pkg.sv | 24 ++
 rtl/vxe_txnreqa_decoder.sv | 24 ++
 rtl/vxe_txnreq_tracker.sv | 136 +++++++++++++
 tb/tb_vxe_txnreq_tracker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vxe_txnreq_tracker_pkg.sv
// ----------------------------------------------------------------------------
// vxe_txnreq_tracker_pkg
// Shared definitions for the VxEngine request-side transaction tracker.
// Holds the field layout of the 44-bit encoded request vector:
//   txnid = [43:38], rnw = [37], addr = [36:0]
// It also holds the word-to-byte address shift and the sizes of the
// in-flight ID table and the outstanding counter.
// No ports; imported by the tracker top and the head decoder.
// ----------------------------------------------------------------------------
package vxe_txnreq_tracker_pkg;

  localparam int VEC_W      = 44;
  localparam int TXNID_W    = 6;
  localparam int TXNID_HI   = 43;
  localparam int TXNID_LO   = 38;
  localparam int RNW_BIT    = 37;
  localparam int ADDR_HI    = 36;
  localparam int ADDR_LO    = 0;
  localparam int ADDR_SHIFT = 3;
  localparam int M_ADDR_W   = 40;
  localparam int NUM_IDS    = 64;
  localparam int CNT_W      = 7;

endpackage

// File: rtl/vxe_txnreqa_decoder.sv
// ----------------------------------------------------------------------------
// vxe_txnreqa_decoder
// Purely combinational decode of one encoded request vector into its
// memory-side fields. The 37-bit word address becomes a 40-bit byte address.
// Ports:
//   vec    in  44  encoded request vector
//   txnid  out 6   transaction ID
//   rnw    out 1   1 = read, 0 = write
//   addr   out 40  byte address {vec[36:0], 3'b000}
// ----------------------------------------------------------------------------
module vxe_txnreqa_decoder
  import vxe_txnreq_tracker_pkg::*;
(
  input  logic [VEC_W-1:0]    vec,
  output logic [TXNID_W-1:0]  txnid,
  output logic                rnw,
  output logic [M_ADDR_W-1:0] addr
);

  assign txnid = vec[TXNID_HI:TXNID_LO];
  assign rnw   = vec[RNW_BIT];
  assign addr  = {vec[ADDR_HI:ADDR_LO], {ADDR_SHIFT{1'b0}}};

endmodule

// File: rtl/vxe_txnreq_tracker.sv
// ----------------------------------------------------------------------------
// vxe_txnreq_tracker
// Request-side transaction tracker. Incoming encoded requests are buffered in
// an in-order FIFO. The FIFO head is decoded and offered to the memory
// interface only while its ID is not already in flight. A 64-bit busy table
// keeps each ID in flight at most once, until a response retires it.
// Ports:
//   clk            in  1   clock, rising edge
//   nrst           in  1   synchronous active-low reset
//   i_req_vec_txn  in  44  encoded request vector
//   i_req_vld      in  1   request valid
//   o_req_rdy      out 1   request ready (FIFO not full)
//   o_m_txnid      out 6   issued transaction ID
//   o_m_rnw        out 1   issued read/not-write
//   o_m_addr       out 40  issued byte address
//   o_m_vld        out 1   issue valid
//   i_m_rdy        in  1   memory interface ready
//   i_rsp_vld      in  1   response / retire valid
//   i_rsp_txnid    in  6   ID being retired
//   o_outstanding  out 7   number of in-flight IDs
//   o_idle         out 1   FIFO empty and nothing in flight
//   o_err          out 1   sticky: a response named an ID that was not busy
// ----------------------------------------------------------------------------
module vxe_txnreq_tracker
  import vxe_txnreq_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [VEC_W-1:0]    i_req_vec_txn,
  input  logic                i_req_vld,
  output logic                o_req_rdy,
  output logic [TXNID_W-1:0]  o_m_txnid,
  output logic                o_m_rnw,
  output logic [M_ADDR_W-1:0] o_m_addr,
  output logic                o_m_vld,
  input  logic                i_m_rdy,
  input  logic                i_rsp_vld,
  input  logic [TXNID_W-1:0]  i_rsp_txnid,
  output logic [CNT_W-1:0]    o_outstanding,
  output logic                o_idle,
  output logic                o_err
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic [VEC_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [NUM_IDS-1:0] busy;
  logic [CNT_W-1:0]   outstanding;
  logic               err;

  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               retire_ok;
  logic [VEC_W-1:0]   head_vec;

  // One extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  assign head_vec = mem[rd_ptr[PTR_W-2:0]];

  vxe_txnreqa_decoder u_head_decoder (
    .vec   (head_vec),
    .txnid (o_m_txnid),
    .rnw   (o_m_rnw),
    .addr  (o_m_addr)
  );

  // Ready depends only on full, so a pop cannot free a slot in the same cycle.
  assign o_req_rdy = !full;
  // The registered busy table is used, so a retire in this cycle does not
  // allow an issue of the same ID until the next cycle.
  assign o_m_vld   = !empty && !busy[o_m_txnid];

  assign push      = i_req_vld && !full;
  assign pop       = o_m_vld && i_m_rdy;
  assign retire_ok = i_rsp_vld && busy[i_rsp_txnid];

  // The FIFO storage is not reset; entries count as valid only between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-2:0]] <= i_req_vec_txn;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Issue and retire never name the same ID in one cycle. Issue needs the bit
  // clear and retire needs it set, so the two busy updates never collide.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy        <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (pop) begin
        busy[o_m_txnid] <= 1'b1;
      end
      if (retire_ok) begin
        busy[i_rsp_txnid] <= 1'b0;
      end
      case ({pop, retire_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (i_rsp_vld && !busy[i_rsp_txnid]) begin
        err <= 1'b1;
      end
    end
  end

  assign o_outstanding = outstanding;
  assign o_idle        = empty && (outstanding == '0);
  assign o_err         = err;

endmodule

// File: tb/tb_vxe_txnreq_tracker.sv
// ----------------------------------------------------------------------------
// tb_vxe_txnreq_tracker
// Directed test-plan scenarios followed by randomized traffic for the tracker.
// The reference model treats the design as a queue of accepted requests plus a
// set of in-flight IDs. The stimulus process pushes each accepted request into
// a scoreboard queue. A separate monitor pops that queue on every issue
// handshake and compares the decoded fields.
// ----------------------------------------------------------------------------
module tb_vxe_txnreq_tracker;

  localparam int DEPTH = 4;

  typedef struct {
    logic [5:0]  id;
    logic        rnw;
    logic [39:0] addr;
  } req_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [43:0] i_req_vec_txn;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic [5:0]  o_m_txnid;
  logic        o_m_rnw;
  logic [39:0] o_m_addr;
  logic        o_m_vld;
  logic        i_m_rdy;
  logic        i_rsp_vld;
  logic [5:0]  i_rsp_txnid;
  logic [6:0]  o_outstanding;
  logic        o_idle;
  logic        o_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_ok = 1'b0;

  req_t mq[$];
  req_t exp_q[$];
  bit   mbusy[64];
  int   mcnt;
  bit   merr;

  always #5 clk = ~clk;

  vxe_txnreq_tracker #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .i_req_vec_txn (i_req_vec_txn),
    .i_req_vld     (i_req_vld),
    .o_req_rdy     (o_req_rdy),
    .o_m_txnid     (o_m_txnid),
    .o_m_rnw       (o_m_rnw),
    .o_m_addr      (o_m_addr),
    .o_m_vld       (o_m_vld),
    .i_m_rdy       (i_m_rdy),
    .i_rsp_vld     (i_rsp_vld),
    .i_rsp_txnid   (i_rsp_txnid),
    .o_outstanding (o_outstanding),
    .o_idle        (o_idle),
    .o_err         (o_err)
  );

  function automatic logic [43:0] mkVec(input int id, input bit rnw, input logic [36:0] addr);
    logic [5:0] id6;
    id6 = 6'(id);
    return {id6, rnw, addr};
  endfunction

  // Decodes with plain arithmetic: the word address times eight gives the byte address.
  function automatic req_t toReq(input logic [43:0] vec);
    req_t r;
    logic [36:0] waddr;
    r.id  = vec[43:38];
    r.rnw = vec[37];
    waddr = vec[36:0];
    r.addr = 40'(waddr) * 40'd8;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelVld();
    return (mq.size() > 0) && !mbusy[mq[0].id];
  endfunction

  // Compares the visible status outputs with the model, away from the clock edge.
  task automatic checkOutput();
    if (!model_ok) return;
    chk("req_rdy",     64'(o_req_rdy),     64'(mq.size() < DEPTH));
    chk("m_vld",       64'(o_m_vld),       64'(modelVld()));
    chk("outstanding", 64'(o_outstanding), 64'(mcnt));
    chk("idle",        64'(o_idle),        64'(mq.size() == 0 && mcnt == 0));
    chk("err",         64'(o_err),         64'(merr));
  endtask

  // Advances the model by one rising edge, using the inputs that were applied.
  task automatic modelStep();
    bit accept;
    bit issue;
    req_t r;
    if (!nrst) begin
      mq.delete();
      exp_q.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mcnt = 0;
      merr = 1'b0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    accept = i_req_vld && (mq.size() < DEPTH);
    issue  = modelVld() && i_m_rdy;
    if (i_rsp_vld) begin
      if (mbusy[i_rsp_txnid]) begin
        mbusy[i_rsp_txnid] = 1'b0;
        mcnt--;
      end else begin
        merr = 1'b1;
      end
    end
    if (issue) begin
      r = mq.pop_front();
      mbusy[r.id] = 1'b1;
      mcnt++;
    end
    if (accept) begin
      r = toReq(i_req_vec_txn);
      mq.push_back(r);
      exp_q.push_back(r);
    end
  endtask

  task automatic applyStimulus(input bit rst_n, input bit vld, input logic [43:0] vec,
                               input bit mrdy, input bit rspv, input int rspid);
    nrst          = rst_n;
    i_req_vld     = vld;
    i_req_vec_txn = vec;
    i_m_rdy       = mrdy;
    i_rsp_vld     = rspv;
    i_rsp_txnid   = 6'(rspid);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idleCycles(input int n, input bit mrdy);
    for (int k = 0; k < n; k++) applyStimulus(1, 0, 44'd0, mrdy, 0, 0);
  endtask

  // Scoreboard monitor: every issue handshake must match the oldest accepted request.
  always @(negedge clk) begin
    req_t e;
    if (model_ok && nrst === 1'b1 && o_m_vld === 1'b1 && i_m_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_issue: got txnid %0h, expected no issue at %0t",
                 o_m_txnid, $time);
      end else begin
        e = exp_q.pop_front();
        chk("issue_txnid", 64'(o_m_txnid), 64'(e.id));
        chk("issue_rnw",   64'(o_m_rnw),   64'(e.rnw));
        chk("issue_addr",  64'(o_m_addr),  64'(e.addr));
      end
    end
  end

  initial begin
    int busy_ids[$];
    int rid;
    applyStimulus(0, 0, 44'd0, 0, 0, 0);
    applyStimulus(0, 0, 44'd0, 0, 0, 0);

    // Basic flow: id 5, read, word address 1, which gives byte address 8.
    applyStimulus(1, 1, mkVec(5, 1, 37'h1), 1, 0, 0);
    idleCycles(2, 1);
    applyStimulus(1, 0, 44'd0, 1, 1, 5);
    idleCycles(1, 1);

    // Fill and stall, followed by a push attempt while the FIFO is full.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, mkVec(20 + i, 0, 37'(i * 3 + 7)), 0, 0, 0);
    applyStimulus(1, 1, mkVec(24, 1, 37'h55), 0, 0, 0);
    idleCycles(5, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 44'd0, 1, 1, 20 + i);

    // Duplicate ID: the second id 9 blocks id 10 until 9 retires.
    applyStimulus(1, 1, mkVec(9, 1, 37'h100), 1, 0, 0);
    applyStimulus(1, 1, mkVec(9, 0, 37'h200), 1, 0, 0);
    applyStimulus(1, 1, mkVec(10, 1, 37'h300), 1, 0, 0);
    idleCycles(2, 1);
    applyStimulus(1, 0, 44'd0, 1, 1, 9);
    idleCycles(3, 1);
    applyStimulus(1, 0, 44'd0, 1, 1, 9);
    applyStimulus(1, 0, 44'd0, 1, 1, 10);

    // Same-cycle issue of id 2 and retire of id 1; id 1 is reusable afterwards.
    applyStimulus(1, 1, mkVec(1, 1, 37'h11), 1, 0, 0);
    applyStimulus(1, 1, mkVec(2, 0, 37'h22), 1, 0, 0);
    applyStimulus(1, 0, 44'd0, 1, 1, 1);
    applyStimulus(1, 1, mkVec(1, 0, 37'h33), 1, 0, 0);
    idleCycles(2, 1);
    applyStimulus(1, 0, 44'd0, 1, 1, 1);
    applyStimulus(1, 0, 44'd0, 1, 1, 2);

    // Bogus retire sets a sticky error that survives until reset.
    applyStimulus(1, 0, 44'd0, 1, 1, 33);
    idleCycles(3, 1);
    applyStimulus(0, 0, 44'd0, 1, 0, 0);
    idleCycles(1, 1);

    // Reset with five IDs in flight and three requests queued.
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, mkVec(40 + i, 1, 37'(i)), 1, 0, 0);
    idleCycles(1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, mkVec(45 + i, 0, 37'(i)), 0, 0, 0);
    applyStimulus(0, 0, 44'd0, 0, 0, 0);
    idleCycles(1, 1);
    applyStimulus(1, 0, 44'd0, 1, 1, 40);
    idleCycles(1, 1);
    applyStimulus(0, 0, 44'd0, 1, 0, 0);

    // Randomized traffic with a narrow ID range so that duplicates are common.
    for (int c = 0; c < 3000; c++) begin
      busy_ids.delete();
      foreach (mbusy[i]) if (mbusy[i]) busy_ids.push_back(i);
      if (busy_ids.size() > 0 && ($urandom % 40) != 0) rid = busy_ids[$urandom % busy_ids.size()];
      else rid = int'($urandom % 64);
      applyStimulus(($urandom % 250) != 0,
                    ($urandom % 4) != 0,
                    mkVec(int'($urandom_range(0, 15)), 1'($urandom), 37'({$urandom, $urandom})),
                    ($urandom % 4) != 0,
                    ($urandom % 3) == 0,
                    rid);
    end

    // Drain: retire everything in flight and let the queue empty, within a bounded budget.
    for (int k = 0; k < 300 && !(mq.size() == 0 && mcnt == 0); k++) begin
      busy_ids.delete();
      foreach (mbusy[i]) if (mbusy[i]) busy_ids.push_back(i);
      if (busy_ids.size() > 0) applyStimulus(1, 0, 44'd0, 1, 1, busy_ids[0]);
      else applyStimulus(1, 0, 44'd0, 1, 0, 0);
    end
    @(negedge clk);
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
    chk("drain_idle", 64'(o_idle), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
